// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM state encoding
// and the legal range of the access latency parameter.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;

endpackage

// File: rtl/data_mem_ctrl_mem_array.sv
// Single-port word memory with byte-enabled synchronous write and
// combinational read. Contents are deliberately left uninitialised.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read is combinational so the controller samples the word as it
    // stands at the access edge, including any earlier completed store.
    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Request/response controller in front of a byte-enabled word memory.
// Legal requests wait LATENCY edges before the access; misaligned or
// out-of-range requests respond immediately with an error and touch nothing.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err
);

    localparam int BE_W = DATA_W / 8;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_mem_ctrl: LATENCY must be within 1..7");
    end
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("data_mem_ctrl: DATA_W must be a non-zero multiple of 8");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $error("data_mem_ctrl: ADDR_W must be within 1..29");
    end

    state_t             state;
    state_t             state_next;
    logic [2:0]         cnt;
    logic [ADDR_W-1:0]  word_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;
    logic               write_q;
    logic               addr_err;
    logic               accept;
    logic               access;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;

    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign accept   = (state == IDLE) && req_valid;
    assign access   = (state == BUSY) && (cnt == 3'd0);
    assign mem_we   = access && write_q;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = addr_err ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 3'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait counter: loaded on a legal accept, counts down while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (accept && !addr_err) begin
            cnt <= 3'(LATENCY - 1);
        end else if (state == BUSY && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Response registers, held until the consumer takes the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept && addr_err) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if (access) begin
            rsp_rdata <= write_q ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
        end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Request capture at the accept edge; later req_* changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            write_q <= req_write;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_q),
        .addr  (word_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: instance 0 runs at LATENCY=2,
// instances 1 and 2 at LATENCY=1 and LATENCY=7.
module tb_data_mem_ctrl;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       req_valid = '0;
    logic [2:0]       req_ready;
    logic [2:0]       req_write = '0;
    logic [2:0][31:0] req_addr  = '0;
    logic [2:0][31:0] req_wdata = '0;
    logic [2:0][3:0]  req_be    = '0;
    logic [2:0]       rsp_valid;
    logic [2:0]       rsp_ready = '0;
    logic [2:0][31:0] rsp_rdata;
    logic [2:0]       rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .LATENCY(7)) u_dut_l7 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on instance k. exp_edges counts edges after the accept
    // edge until rsp_valid is seen (0 = already valid right after accept).
    // hold > 0 stalls rsp_ready for that many cycles while a competing store
    // to the same address is presented, and keeps it presented across the
    // handshake edge.
    task automatic do_req(input string tag, input int k, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int hold, input int exp_edges,
                          input logic [31:0] exp_rd, input logic exp_err);
        int edges;
        @(negedge clk);
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_be[k]    = be;
        req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        check({tag, "_busy_ready"}, 64'(req_ready[k]), 64'd0);
        edges = 0;
        while (!rsp_valid[k] && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        check({tag, "_rdata"}, 64'(rsp_rdata[k]), 64'(exp_rd));
        check({tag, "_err"}, 64'(rsp_err[k]), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                req_write[k] = 1'b1;
                req_addr[k]  = addr;
                req_wdata[k] = 32'h0;
                req_be[k]    = 4'hF;
                req_valid[k] = 1'b1;
            end
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(rsp_valid[k]), 64'd1);
            check({tag, "_hold_rdata"}, 64'(rsp_rdata[k]), 64'(exp_rd));
            check({tag, "_hold_err"}, 64'(rsp_err[k]), 64'(exp_err));
            check({tag, "_hold_ready"}, 64'(req_ready[k]), 64'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        req_valid[k] = 1'b0;
        check({tag, "_idle_ready"}, 64'(req_ready[k]), 64'd1);
        check({tag, "_idle_valid"}, 64'(rsp_valid[k]), 64'd0);
    endtask

    initial begin
        #1;
        check("rst_ready", 64'(req_ready[0]), 64'd1);
        check("rst_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_err", 64'(rsp_err[0]), 64'd0);
        check("rst_rdata", 64'(rsp_rdata[0]), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full store, load back, then partial store over it.
        do_req("st_full", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 2, 32'h0, 1'b0);
        do_req("ld_full", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'hDEADBEEF, 1'b0);
        do_req("st_byte0", 0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 2, 32'h0, 1'b0);
        do_req("ld_byte0", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'hDEADBEAA, 1'b0);
        do_req("st_hi", 0, 1'b1, 32'h10, 32'h77665544, 4'hC, 0, 2, 32'h0, 1'b0);
        do_req("ld_hi", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'h7766BEAA, 1'b0);
        do_req("st_be0", 0, 1'b1, 32'h10, 32'h11111111, 4'h0, 0, 2, 32'h0, 1'b0);
        do_req("ld_be0", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'h7766BEAA, 1'b0);

        // Error requests: misaligned, out of range, and an out-of-range store
        // whose low bits alias word 0.
        do_req("st_w0", 0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, 0, 2, 32'h0, 1'b0);
        do_req("ld_mis", 0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1);
        do_req("ld_oor", 0, 1'b0, 32'h400, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1);
        do_req("st_oor", 0, 1'b1, 32'h400, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1);
        do_req("st_mis", 0, 1'b1, 32'h12, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1);
        do_req("ld_w0", 0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 2, 32'h55AA55AA, 1'b0);
        do_req("ld_after_err", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'h7766BEAA, 1'b0);

        // Back-pressure: response held five cycles while a store is offered.
        do_req("ld_hold", 0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 2, 32'h7766BEAA, 1'b0);
        do_req("ld_no_intr", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2, 32'h7766BEAA, 1'b0);

        // Reset during BUSY aborts a store before its access edge.
        do_req("st_pre", 0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 2, 32'h0, 1'b0);
        @(negedge clk);
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("abort_busy", 64'(req_ready[0]), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", 64'(req_ready[0]), 64'd1);
        check("abort_valid", 64'(rsp_valid[0]), 64'd0);
        check("abort_err", 64'(rsp_err[0]), 64'd0);
        check("abort_rdata", 64'(rsp_rdata[0]), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req("ld_abort", 0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 2, 32'hCAFEF00D, 1'b0);

        // Reset during RESP drops the pending response.
        @(negedge clk);
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h20;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("resp_pending", 64'(rsp_valid[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("resp_drop_valid", 64'(rsp_valid[0]), 64'd0);
        check("resp_drop_rdata", 64'(rsp_rdata[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("resp_drop_ready", 64'(req_ready[0]), 64'd1);

        // Latency sweep at the two extremes.
        do_req("l1_st", 1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, 0, 1, 32'h0, 1'b0);
        do_req("l1_ld", 1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1, 32'h0BADF00D, 1'b0);
        do_req("l1_err", 1, 1'b0, 32'h9, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1);
        do_req("l7_st", 2, 1'b1, 32'h8, 32'hA5A5C3C3, 4'hF, 0, 7, 32'h0, 1'b0);
        do_req("l7_ld", 2, 1'b0, 32'h8, 32'h0, 4'h0, 0, 7, 32'hA5A5C3C3, 1'b0);
        do_req("l7_err", 2, 1'b0, 32'h800, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule
